// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, controller states,
// and the divide-by-zero quotient pattern.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  localparam int unsigned MaxW = 128;

  // All-ones quotient of width w, returned right-aligned in a MaxW-bit vector.
  function automatic logic [MaxW-1:0] div0_lo(input int unsigned w);
    return {MaxW{1'b1}} >> (MaxW - w);
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Execute-stage request/response bundle between the pipeline and the HI/LO unit.
interface mdu_hilo_if #(
  parameter int unsigned W = 32
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/div_iter.sv
// One restoring-division step: shift a dividend bit into the partial remainder and
// subtract the divisor when it fits.
module div_iter #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);
  logic [W:0] trial;
  logic [W:0] diff;

  always_comb begin
    trial = {rem_i, bit_i};
    diff  = trial - {1'b0, dvsr_i};
    q_o   = ~diff[W];
    // rem_i < dvsr_i keeps both candidates within W bits.
    rem_o = q_o ? diff[W-1:0] : trial[W-1:0];
  end
endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MDU_FAST_MUL_EN for a single-pass combinational multiply.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input logic         clk,
  input logic         rst,
  mdu_hilo_if.slave   bus
);
  localparam int unsigned CW = $clog2(W) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic             neg_q, neg_d, negr_q, negr_d, mul_q, mul_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             is_signed, is_mul, sa, sb;
  logic [W-1:0]     mag_a, mag_b;
  logic [W:0]       mul_sum;
  logic [W-1:0]     div_rem;
  logic             div_q;
  logic [2*W-1:0]   prod_raw, prod_fix;
  logic [W-1:0]     quo_fix, rem_fix;

  div_iter #(.W(W)) u_div_iter (
    .rem_i  (acc_q[2*W-1:W]),
    .bit_i  (acc_q[W-1]),
    .dvsr_i (opb_q),
    .rem_o  (div_rem),
    .q_o    (div_q)
  );

  always_comb begin
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    is_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    sa        = is_signed & bus.a[W-1];
    sb        = is_signed & bus.b[W-1];
    mag_a     = sa ? -bus.a : bus.a;
    mag_b     = sb ? -bus.b : bus.b;
    // Shift-add: low half of acc holds the unconsumed multiplier bits.
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opa_q : {W{1'b0}})};
`ifdef MDU_FAST_MUL_EN
    prod_raw  = (2*W)'(opa_q) * (2*W)'(opb_q);
`else
    prod_raw  = acc_q;
`endif
    prod_fix  = neg_q ? -prod_raw : prod_raw;
    quo_fix   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix   = negr_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    mul_d   = mul_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start && !bus.flush) begin
          opa_d  = mag_a;
          opb_d  = mag_b;
          mul_d  = is_mul;
          cnt_d  = CW'(W - 1);
          neg_d  = sa ^ sb;
          negr_d = sa;
          if (is_mul) begin
            acc_d = {{W{1'b0}}, mag_b};
`ifdef MDU_FAST_MUL_EN
            state_d = FIX;
`else
            state_d = MUL;
`endif
          end else if (bus.b == '0) begin
            // Divide by zero skips iteration; FIX passes acc through unsigned.
            acc_d   = {bus.a, W'(div0_lo(W))};
            neg_d   = 1'b0;
            negr_d  = 1'b0;
            state_d = FIX;
          end else begin
            acc_d   = {{W{1'b0}}, mag_a};
            state_d = DIV;
          end
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[W-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      DIV: begin
        acc_d = {div_rem, acc_q[W-2:0], div_q};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (mul_q) begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush && (state_q != IDLE)) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      mul_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      mul_q   <= mul_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: arithmetic reference model checked every cycle, plus directed
// vectors with hand-computed HI/LO and completion cycles.
module tb_mdu_hilo;
  localparam int unsigned W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = W + 2;
`endif
  localparam int DivLat = W + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_hilo_if #(.W(W)) bus ();

  mdu_hilo #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} straight from the arithmetic definition.
  function automatic logic [63:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      default: begin
        if (b == 32'b0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic int done_cycle(input logic [1:0] op, input logic [31:0] b);
    if (op[1] == 1'b0) return MulLat;
    if (b == 32'b0) return 2;
    return DivLat;
  endfunction

  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus.hi_we) m_hi <= bus.wdata;
        if (bus.lo_we) m_lo <= bus.wdata;
        if (bus.start && !bus.flush) begin
          m_res  <= model_result(bus.op, bus.a, bus.b);
          m_busy <= 1'b1;
          m_left <= done_cycle(bus.op, bus.b) - 1;
        end
      end else if (bus.flush) begin
        m_busy <= 1'b0;
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_hi   <= m_res[63:32];
        m_lo   <= m_res[31:0];
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc busy", 64'(bus.busy), 64'(m_busy));
      chk("cyc done", 64'(bus.done), 64'(m_done));
      chk("cyc hi", 64'(bus.hi), 64'(m_hi));
      chk("cyc lo", 64'(bus.lo), 64'(m_lo));
    end
  end

  // Called just after a rising edge; start is high for cycle 0.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int n;
    bit seen;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
      end
      if (bus.done) seen = 1'b1;
    end
    chk({name, " done cycle"}, 64'(n), 64'(lat));
    chk({name, " hi"}, 64'(bus.hi), 64'(ehi));
    chk({name, " lo"}, 64'(bus.lo), 64'(elo));
    chk({name, " model"}, {m_hi, m_lo}, {ehi, elo});
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);

    run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat, 32'hFFFF_FFFE, 32'h1);
    run_op("mult -2*3", 2'b00, 32'hFFFF_FFFE, 32'd3, MulLat, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, DivLat, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, DivLat, 32'h1, 32'hFFFF_FFFD);
    run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DivLat, 32'h0, 32'h8000_0000);

    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_AAAA;
    run_op("mtlo+multu", 2'b01, 32'd2, 32'd3, MulLat, 32'h0, 32'h6);

    run_op("divu by 0", 2'b11, 32'd10, 32'd0, 2, 32'hA, 32'hFFFF_FFFF);

    // MTHI then a flushed DIVU: HI/LO must keep their pre-flush values.
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    bus.op = 2'b11;
    bus.a = 32'd100;
    bus.b = 32'd7;
    bus.start = 1'b1;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) bus.start = 1'b0;
      if (n == 5) bus.flush = 1'b1;
      if (n == 6) begin
        bus.flush = 1'b0;
        chk("flush busy c6", 64'(bus.busy), 64'd0);
      end
      if (n > 1 && bus.done) chk("flush no done", 64'(bus.done), 64'd0);
    end
    chk("flush hi", 64'(bus.hi), 64'h1234_5678);
    chk("flush lo", 64'(bus.lo), 64'hFFFF_FFFF);

    // A start arriving in cycle 3 of a running DIV must not disturb it.
    bus.op = 2'b10;
    bus.a = 32'd100;
    bus.b = 32'd7;
    bus.start = 1'b1;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) bus.start = 1'b0;
      if (n == 3) begin
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.a = 32'd5;
        bus.b = 32'd5;
      end
      if (n == 4) bus.start = 1'b0;
      if (bus.done) break;
    end
    chk("ignored start done cycle", 64'(n), 64'(DivLat));
    chk("ignored start lo", 64'(bus.lo), 64'd14);
    chk("ignored start hi", 64'(bus.hi), 64'd2);

    // Reset in cycle 10 of a second op clears everything.
    bus.op = 2'b11;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    bus.start = 1'b1;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) bus.start = 1'b0;
      if (n == 10) rst = 1'b1;
      if (n == 11) begin
        rst = 1'b0;
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst hi", 64'(bus.hi), 64'd0);
        chk("rst lo", 64'(bus.lo), 64'd0);
      end
      if (n > 11 && bus.done) chk("rst no done", 64'(bus.done), 64'd0);
    end

    run_op("divu 1000/3", 2'b11, 32'd1000, 32'd3, DivLat, 32'd1, 32'd333);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers, placed in the execute stage beside the ALU.
- Supports MULT, MULTU, DIV and DIVU, plus MTHI/MTLO writes.
- Reports busy so the hazard unit can stall F/D/E while a multi-cycle operation runs.
- Generalises the single-cycle execute path to W-bit operands with iterative, cancellable arithmetic.

Parameters:
- W, 32, operand width; HI and LO are each W bits; must be even and >= 4.
- CW, $clog2(W)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request an operation; accepted only when idle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  W  rs operand (multiplicand / dividend)
- b  in  W  rt operand (multiplier / divisor)
- flush  in  1  cancel any in-flight operation
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wdata  in  W  MTHI/MTLO data
- busy  out  1  operation in progress; registered
- done  out  1  one-cycle pulse; HI/LO hold new result
- hi  out  W  HI register
- lo  out  W  LO register

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; counter and accumulators cleared.
- States: IDLE, MUL, DIV, FIX.
- start is accepted when state==IDLE and flush==0.
  - Operand magnitudes are latched, plus sign flags for signed ops.
  - Next state is MUL for op[1]==0, DIV for op[1]==1; counter=W-1.
- start while busy is ignored; no queueing.
- MUL: radix-2 shift-add, one multiplier bit per cycle, W cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle, W cycles, then FIX.
- FIX, one cycle: apply signs, write HI/LO at the closing edge, go to IDLE, set done=1 for the following cycle.
  - Signed product is negated when sign(a) != sign(b).
  - Quotient is negated when signs differ; remainder takes the dividend's sign.
- Timing: start sampled in cycle 0; busy=1 in cycles 1..W+1; done=1 and new HI/LO visible in cycle W+2; busy=0 in W+2.
- Full product: HI = upper W bits, LO = lower W bits.
- Divide: LO = quotient, HI = remainder.
- Divide by zero, detected at start: no iteration. The unit goes straight to FIX with LO = all ones and HI = a, so the result appears in cycle 2.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0; no trap.
- flush in any non-IDLE state: next state IDLE, busy=0, no HI/LO update, no done pulse. flush together with start in IDLE: start is discarded.
- hi_we/lo_we: applied at the edge only when state==IDLE.
  - Ignored while busy; the hazard unit prevents this case.
  - Same-cycle write and start: the write takes effect, and the later result overwrites it.
- A FIX-cycle update has priority over a concurrent hi_we/lo_we (not reachable when stalled correctly).
- done is low in every cycle except the single completion cycle.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MULT/MULTU compute the full 2W-bit product combinationally from the latched magnitudes and go IDLE -> FIX directly. busy=1 in cycle 1 only; done and HI/LO are visible in cycle 2.
- Undefined: iterative multiply taking W+2 cycles, as above. Divide behaviour is identical in both cases.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum: IDLE, MUL, DIV, FIX;
  - the divide-by-zero LO constant, expressed for width W.
- One sub-module, div_iter: one restoring-division step (W-bit partial remainder, divisor, shifted-in dividend bit -> next remainder and quotient bit). It is instantiated once and iterated by the controller.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle 34, HI=0xFFFFFFFE, LO=0x00000001; busy high in cycles 1..33.
- MULT a=0xFFFFFFFE (-2), b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. With MDU_FAST_MUL_EN, done in cycle 2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=10, b=0 -> done in cycle 2, LO=0xFFFFFFFF, HI=0x0000000A.
- MTHI 0x12345678 when idle, then DIVU 100/7 with flush in cycle 5 -> busy low in cycle 6, no done, HI stays 0x12345678, LO unchanged.
- Assert start in cycle 3 of a running DIV and rst in cycle 10 of a second operation -> the extra start is ignored; after rst, HI=LO=0, busy=0, done=0.
